// File: rtl/spr_pkg.sv
// Shared types and default widths for the single-port RAM burst controller.
package spr_pkg;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/spr_burst_ctrl_if.sv
// Host-side bus of the burst controller: command, write-beat and read-beat channels.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid may not depend on ready. The read stream has no ready and must always be taken.
interface spr_burst_ctrl_if #(
    parameter int AW = spr_pkg::AW,
    parameter int DW = spr_pkg::DW,
    parameter int LW = spr_pkg::LW
) (
    input logic CLK
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;

    modport master (
        input  CLK,
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  CLK,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/SPR_design.sv
// Single-port RAM: synchronous write, registered read address, combinational Q.
module SPR_design #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          WEN,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] Q
);
    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_addr;

    always_ff @(posedge CLK) begin
        if (WEN) begin
            r_mem[address] <= data;
        end
        r_addr <= address;
    end

    assign Q = r_mem[r_addr];
endmodule

// File: rtl/spr_burst_ctrl.sv
// Burst read/write initiator for one SPR_design RAM; sole driver of the RAM port.
module spr_burst_ctrl
    import spr_pkg::*;
#(
    parameter int AW = spr_pkg::AW,
    parameter int DW = spr_pkg::DW,
    parameter int LW = spr_pkg::LW
) (
    input  logic              CLK,
    input  logic              RST,
    spr_burst_ctrl_if.slave   bus,
    output logic              ram_wen,
    output logic [AW-1:0]     ram_address,
    output logic [DW-1:0]     ram_data,
    input  logic [DW-1:0]     ram_q,
    output state_t            dbg_state
);
    state_t        r_state;
    logic [AW-1:0] r_cur_addr;
    logic [LW-1:0] r_beat_cnt;
    logic [LW-1:0] r_len;
    logic          r_rd_pend;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          w_wr_fire;
    logic          w_last;

    assign w_wr_fire = (r_state == WRITE) && bus.wr_valid;
    assign w_last    = (r_beat_cnt == r_len);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cur_addr <= '0;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            // Q of an address issued last cycle is valid now; register it here.
            r_rd_pend  <= (r_state == READ);
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= ram_q;
            end

            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cur_addr <= bus.cmd_addr;
                        r_len      <= bus.cmd_len;
                        r_beat_cnt <= '0;
                        r_state    <= bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (bus.wr_valid) begin
                        r_cur_addr <= r_cur_addr + AW'(1);
                        r_beat_cnt <= r_beat_cnt + LW'(1);
                        if (w_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                READ: begin
                    r_cur_addr <= r_cur_addr + AW'(1);
                    r_beat_cnt <= r_beat_cnt + LW'(1);
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.wr_ready  = (r_state == WRITE);
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.busy      = (r_state != IDLE) || r_rd_pend || r_rd_valid;

    assign ram_wen     = w_wr_fire;
    assign ram_address = r_cur_addr;
    assign ram_data    = bus.wr_data;
    assign dbg_state   = r_state;
endmodule

// File: doc/spr_burst_ctrl.md
Name: spr_burst_ctrl

Overview:
Initiator-side controller for the team's single-port RAM (SPR_design: WEN, address, data, Q; write-first-cycle, registered read address, combinational Q).
- Accepts burst read/write commands over a valid/ready handshake.
- Streams write beats into the RAM and returns read beats as a registered valid-qualified stream.
- Sits between a DMA/test engine and one RAM instance; it is the only driver of the RAM port.

Parameters:
AW, 8, RAM address width; address wraps modulo 2^AW
DW, 16, data width
LW, 8, burst length field width; cmd_len = beats-1, max 2^LW beats

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  asynchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  AW  start address
cmd_len  in  LW  beats minus one
wr_valid  in  1  write beat valid
wr_ready  out  1  high only in WRITE
wr_data  in  DW  write beat data
rd_valid  out  1  registered, one cycle per returned beat
rd_data  out  DW  registered read data
busy  out  1  state!=IDLE or read beats still in flight
ram_wen  out  1  to RAM WEN
ram_address  out  AW  to RAM address
ram_data  out  DW  to RAM data
ram_q  in  DW  from RAM Q

Behaviour:
- Reset (async, RST=1): state=IDLE; cur_addr, beat_cnt, len_r =0; rd_pend=0; rd_valid=0; rd_data=0. cmd_ready=1 once RST deasserts. RAM contents are not touched.
- FSM states IDLE, WRITE, READ.
- IDLE: cmd_valid&cmd_ready latches cmd_addr→cur_addr, cmd_len→len_r, beat_cnt=0. Next state is WRITE or READ per cmd_write.
- WRITE:
  - wr_ready=1; ram_wen=wr_valid; ram_address=cur_addr; ram_data=wr_data, all combinational.
  - Each accepted beat increments cur_addr (wrap FF→00 at AW=8) and beat_cnt.
  - wr_valid=0 stalls: no write, address held.
  - The beat with beat_cnt==len_r returns to IDLE.
- READ:
  - ram_wen=0; ram_address=cur_addr; one address issued every cycle with no stall. cur_addr and beat_cnt increment per cycle.
  - Issue with beat_cnt==len_r returns to IDLE.
- Outside WRITE: ram_wen=0. ram_data is don't-care; drive wr_data.
- Read pipeline:
  - Address issued in cycle N is captured by the RAM at the end of N, and Q is valid in N+1.
  - rd_pend (set in the cycle after an issue) causes rd_data<=ram_q at the end of N+1.
  - rd_valid=1 in N+2. A command accepted in cycle C gives first issue at C+1 and first rd_valid at C+3.
- No rd backpressure: the consumer must take every rd_valid beat.
- cmd_ready returns in the cycle after the last issue/beat. A new command may be accepted while the final read beat is still in flight; the rd stream continues unaffected.
- Read-after-write: a write at edge E followed by a read issued after E returns the new data. A write in the cycle of the final read capture does not corrupt that beat, because capture and write share the same edge.
- busy = (state!=IDLE) | rd_pend | rd_valid.
- Reset mid-burst: immediate abort. No further ram_wen, rd_valid drops to 0, and partially written data remains in the RAM.
- cmd_len=0: single beat.
- cmd_len=all-ones: 2^LW beats; the address wraps if 2^LW > 2^AW - cmd_addr.

Decomposition:
- Package spr_pkg: state enum (IDLE, WRITE, READ) and default width constants AW/DW/LW.
- No sub-module inside the controller; beat counting and address increment are inline.
- The testbench instantiates spr_burst_ctrl connected to one SPR_design (AW=8, DW=16, depth=256).

Test Plan:
1. Reset: hold RST 3 cycles → cmd_ready=1, busy=0, rd_valid=0, rd_data=0, ram_wen=0. Assert RST mid-cycle asynchronously → outputs clear before the next edge.
2. Single write/read: write addr 0x12 len 0 data 0xBEEF, then read addr 0x12 len 0 accepted at C → rd_valid only at C+3, rd_data=0xBEEF.
3. Write burst with gap: addr 0x40 len 3, data 0x1111,0x2222,(wr_valid low 2 cycles),0x3333,0x4444 → exactly 4 ram_wen pulses at 0x40..0x43. Read back len 3 → 4 consecutive rd_valid with data in order.
4. Wrap: write then read addr 0xFE len 3 → ram_address sequence FE,FF,00,01; read data matches written values.
5. Back-to-back: read len 1 at 0x40, then write 0x40 data 0xAAAA accepted the cycle cmd_ready returns → read beats are 0x1111,0x2222. A subsequent read of 0x40 returns 0xAAAA.
6. Reset mid-burst: write len 7 at 0x80, RST after beat 3 → only 0x80..0x82 modified, state IDLE, no further ram_wen.
